mem_ctrl_fsm: RTL and testbench

MEM_CTRL_FSM -- requirements
Module: mem_ctrl_fsm

---
 rtl/mem_ctrl_fsm.sv | 164 ++++++++++++++++
 tb/tb_mem_ctrl_fsm.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl_fsm.sv
// Sequences radix-16 FFT memory passes: reads every group per stage, then drains the write-back pipe.
// Latency: write-back for a group follows its read by PIPE_LAT un-held cycles; done follows the last drain cycle.
// Backpressure: hold freezes all state and masks the strobes; start is accepted only in IDLE without hold.
module mem_ctrl_fsm #(
  parameter int MA_W     = 8,
  parameter int N_STAGE  = 3,
  parameter int PIPE_LAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            hold,
  output logic            busy,
  output logic            done,
  output logic            r_enable,
  output logic [MA_W-1:0] rd_MA,
  output logic [3:0]      rd_rot,
  output logic            w_enable,
  output logic [MA_W-1:0] wr_MA,
  output logic [3:0]      wr_rot,
  output logic [3:0]      stage_idx,
  output logic            LAST_STAGE
);

  // Number of base-16 digits in a group address; the top digit is zero-extended.
  localparam int ND    = (MA_W + 3) / 4;
  localparam int CNT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [MA_W-1:0]  G_LAST     = '1;
  localparam logic [3:0]       STAGE_LAST = 4'(N_STAGE - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(PIPE_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state;
  logic [MA_W-1:0]  g_q;
  logic [MA_W-1:0]  g_next;
  logic [3:0]       rot_q;
  logic [3:0]       stage_q;
  logic [CNT_W-1:0] drain_cnt;
  logic             r_en_q;
  logic             busy_q;
  logic             done_q;

  // Write-back delay line, one entry per pipeline stage of the datapath.
  logic [PIPE_LAT-1:0]           sr_en;
  logic [PIPE_LAT-1:0]           sr_last;
  logic [PIPE_LAT-1:0][MA_W-1:0] sr_ma;
  logic [PIPE_LAT-1:0][3:0]      sr_rot;

  // Bank rotation: modulo-16 sum of the address digits spreads each butterfly across all banks.
  function automatic logic [3:0] digit_sum(input logic [MA_W-1:0] a);
    logic [4*ND-1:0] e;
    logic [3:0]      s;
    e          = '0;
    e[MA_W-1:0] = a;
    s          = '0;
    for (int i = 0; i < ND; i++) begin
      s = s + e[4*i +: 4];
    end
    return s;
  endfunction

  assign g_next = g_q + 1'b1;

  // Main sequencer: stage/group counters, drain timer and registered read-side outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      g_q       <= '0;
      rot_q     <= '0;
      stage_q   <= '0;
      drain_cnt <= '0;
      r_en_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else if (!hold) begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            state   <= S_READ;
            g_q     <= '0;
            rot_q   <= '0;
            stage_q <= '0;
            r_en_q  <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        S_READ: begin
          if (g_q == G_LAST) begin
            state     <= S_DRAIN;
            g_q       <= '0;
            rot_q     <= '0;
            r_en_q    <= 1'b0;
            drain_cnt <= '0;
          end else begin
            g_q   <= g_next;
            rot_q <= digit_sum(g_next);
          end
        end
        S_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) begin
            if (stage_q != STAGE_LAST) begin
              state   <= S_READ;
              stage_q <= stage_q + 1'b1;
              r_en_q  <= 1'b1;
            end else begin
              state   <= S_DONE;
              stage_q <= '0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end
        S_DONE: begin
          state  <= S_IDLE;
          done_q <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Delay line: captures each read slot; idle slots carry all-zero fields so taps read 0 when not writing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr_en   <= '0;
      sr_last <= '0;
      sr_ma   <= '0;
      sr_rot  <= '0;
    end else if (!hold) begin
      for (int i = PIPE_LAT - 1; i > 0; i--) begin
        sr_en[i]   <= sr_en[i-1];
        sr_last[i] <= sr_last[i-1];
        sr_ma[i]   <= sr_ma[i-1];
        sr_rot[i]  <= sr_rot[i-1];
      end
      sr_en[0]   <= r_en_q;
      sr_last[0] <= r_en_q & (stage_q == STAGE_LAST);
      sr_ma[0]   <= r_en_q ? g_q : '0;
      sr_rot[0]  <= r_en_q ? rot_q : '0;
    end
  end

  // Strobes are masked by hold in the same cycle; addresses simply keep their registered values.
  assign r_enable   = r_en_q & ~hold;
  assign done       = done_q & ~hold;
  assign busy       = busy_q;
  assign rd_MA      = g_q;
  assign rd_rot     = rot_q;
  assign stage_idx  = stage_q;
  assign w_enable   = sr_en[PIPE_LAT-1] & ~hold;
  assign wr_MA      = sr_ma[PIPE_LAT-1];
  assign wr_rot     = sr_rot[PIPE_LAT-1];
  assign LAST_STAGE = sr_last[PIPE_LAT-1];

endmodule

// File: tb/tb_mem_ctrl_fsm.sv
// Bench for mem_ctrl_fsm: timeline model indexed by un-held cycles since start.
// Latency: outputs compared every cycle on the falling edge.
// Backpressure: random and directed hold, start spam and mid-run reset.
module tb_mem_ctrl_fsm;

  localparam int MA_W     = 8;
  localparam int N_STAGE  = 3;
  localparam int PIPE_LAT = 4;
  localparam int NG       = 1 << MA_W;
  localparam int P        = NG + PIPE_LAT;
  localparam int TOT      = N_STAGE * P;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            hold;
  logic            busy;
  logic            done;
  logic            r_enable;
  logic [MA_W-1:0] rd_MA;
  logic [3:0]      rd_rot;
  logic            w_enable;
  logic [MA_W-1:0] wr_MA;
  logic [3:0]      wr_rot;
  logic [3:0]      stage_idx;
  logic            LAST_STAGE;

  int checks = 0;
  int errors = 0;

  // Model: m_act says a transform is running, m_t is the un-held cycle number since start (1-based).
  bit m_act = 1'b0;
  int m_t   = 0;

  mem_ctrl_fsm #(.MA_W(MA_W), .N_STAGE(N_STAGE), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .hold(hold),
    .busy(busy), .done(done), .r_enable(r_enable), .rd_MA(rd_MA), .rd_rot(rd_rot),
    .w_enable(w_enable), .wr_MA(wr_MA), .wr_rot(wr_rot),
    .stage_idx(stage_idx), .LAST_STAGE(LAST_STAGE)
  );

  always #5 clk = ~clk;

  function automatic int rot_of(input int ma);
    int s;
    int v;
    s = 0;
    v = ma;
    while (v > 0) begin
      s = s + (v % 16);
      v = v / 16;
    end
    return s % 16;
  endfunction

  // Cycle t of the transform is a read slot if it falls in the first NG cycles of its stage period.
  function automatic bit is_rd(input int t);
    return (t >= 1) && (t <= TOT) && (((t - 1) % P) < NG);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_act <= 1'b0;
      m_t   <= 0;
    end else if (!hold) begin
      if (m_act) begin
        if (m_t == TOT + 1) begin
          m_act <= 1'b0;
          m_t   <= 0;
        end else begin
          m_t <= m_t + 1;
        end
      end else if (start) begin
        m_act <= 1'b1;
        m_t   <= 1;
      end
    end
  end

  int c_tw;
  bit c_rd;
  bit c_wr;

  always @(negedge clk) begin
    c_rd = is_rd(m_t);
    c_tw = m_t - PIPE_LAT;
    c_wr = is_rd(c_tw);
    chk("busy", busy, int'(m_act && m_t <= TOT));
    chk("done", done, int'(m_t == TOT + 1 && !hold));
    chk("r_enable", r_enable, int'(c_rd && !hold));
    if (c_rd) begin
      chk("rd_MA", rd_MA, (m_t - 1) % P);
      chk("rd_rot", rd_rot, rot_of((m_t - 1) % P));
      chk("stage_idx", stage_idx, (m_t - 1) / P);
    end
    chk("w_enable", w_enable, int'(c_wr && !hold));
    chk("wr_MA", wr_MA, c_wr ? (c_tw - 1) % P : 0);
    chk("wr_rot", wr_rot, c_wr ? rot_of((c_tw - 1) % P) : 0);
    chk("LAST_STAGE", LAST_STAGE, int'(c_wr && ((c_tw - 1) / P) == N_STAGE - 1));
    if (rst) begin
      chk("rst_rd_MA", rd_MA, 0);
      chk("rst_rd_rot", rd_rot, 0);
      chk("rst_stage_idx", stage_idx, 0);
    end
    if (r_enable && rd_MA == 8'h37) chk("rot_lit_37", rd_rot, 4'hA);
    if (r_enable && rd_MA == 8'hFF) chk("rot_lit_FF", rd_rot, 4'hE);
    if (w_enable && wr_MA == 8'h37) chk("wr_rot_lit_37", wr_rot, 4'hA);
  end

  // One transform started at cycle 0, with literal timing expectations.
  task automatic run_measure(input int hold_at, input int exp_done, input bit spam);
    int first_rd;
    int first_wr;
    int done_at;
    int busy_n;
    int wr_n;
    int last_n;
    first_rd = -1; first_wr = -1; done_at = -1;
    busy_n = 0; wr_n = 0; last_n = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int rel = 1; rel <= 1200 && done_at < 0; rel++) begin
      hold  = (hold_at >= 0) && (rel >= hold_at) && (rel < hold_at + 3);
      start = spam && ($urandom_range(0, 7) == 0);
      @(negedge clk);
      if (r_enable && first_rd < 0) first_rd = rel;
      if (w_enable && first_wr < 0) first_wr = rel;
      if (busy) busy_n++;
      if (w_enable) wr_n++;
      if (w_enable && LAST_STAGE) last_n++;
      if (done) done_at = rel;
      if (hold) begin
        chk("hold_rd_MA", rd_MA, 100);
        chk("hold_r_enable", r_enable, 0);
      end
      if (hold_at >= 0 && rel == hold_at + 3) begin
        chk("resume_rd_MA", rd_MA, 100);
        chk("resume_r_enable", r_enable, 1);
      end
      @(posedge clk); #1;
    end
    hold = 1'b0;
    start = 1'b0;
    chk("first_read_cycle", first_rd, 1);
    chk("first_write_cycle", first_wr, 5);
    chk("done_cycle", done_at, exp_done);
    chk("busy_cycles", busy_n, exp_done - 1);
    chk("write_count", wr_n, N_STAGE * NG);
    chk("last_stage_writes", last_n, NG);
  endtask

  // Random hold and start traffic; transform must still finish with one done pulse.
  task automatic run_random();
    int done_n;
    int cyc;
    done_n = 0;
    cyc = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    while (done_n == 0 && cyc < 3000) begin
      hold  = ($urandom_range(0, 7) == 0);
      start = ($urandom_range(0, 15) == 0);
      @(negedge clk);
      if (done) done_n++;
      @(posedge clk); #1;
      cyc++;
    end
    hold = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    chk("random_done_seen", done_n, 1);
    chk("random_idle_after", busy, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    hold = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", busy, 0);
    chk("reset_r_enable", r_enable, 0);
    chk("reset_w_enable", w_enable, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_measure(-1, 781, 1'b0);
    run_measure(101, 784, 1'b0);
    run_measure(-1, 781, 1'b1);

    // start together with hold in IDLE is ignored
    start = 1'b1;
    hold = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    hold = 1'b0;
    @(negedge clk);
    chk("start_under_hold_busy", busy, 0);
    chk("start_under_hold_r_enable", r_enable, 0);
    @(posedge clk); #1;

    // reset in the middle of stage 1 aborts without done
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (299) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_r_enable", r_enable, 0);
    chk("midrst_w_enable", w_enable, 0);
    chk("midrst_rd_MA", rd_MA, 0);
    chk("midrst_wr_MA", wr_MA, 0);
    chk("midrst_stage_idx", stage_idx, 0);
    chk("midrst_done", done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    run_measure(-1, 781, 1'b0);

    repeat (3) run_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
